// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the multicycle MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Optional feature macro: CTRL_BEQ_EN (decode opcode 000100 as BEQ instead of illegal).
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        PCcontrol,
    output logic        Mux1control,
    output logic [1:0]  Mux6control,
    output logic        Mux2control,
    output logic        Mem_WE,
    output logic        Dec1control,
    output logic        Reg_WE,
    output logic [1:0]  RegDst,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcB,
    output logic [2:0]  ALU3op,
    output logic        retire,
    output logic        illegal,
    output logic [31:0] retired_count
);

    localparam int unsigned CNT_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, RTYPE_EX, RTYPE_WB,
        IMM_EX, IMM_WB, BRANCH, JUMP, JAL, JR, ILLEGAL
    } state_t;

    state_t state, next_state;
    logic   final_c;
    logic [2:0] rtype_op_c;
    logic [2:0] imm_op_c;
    logic       taken_c;

    // ALU command for R-type follows funct; immediates follow opcode
    always_comb begin
        rtype_op_c = ALU_ADD;
        if (funct == FN_SUB)      rtype_op_c = ALU_SUB;
        else if (funct == FN_SLT) rtype_op_c = ALU_SLT;
        imm_op_c = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
`ifdef CTRL_BEQ_EN
        taken_c = (opcode == OP_BEQ) ? zero : ~zero;
`else
        taken_c = ~zero;
`endif
    end

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            retired_count <= '0;
        end else begin
            state <= next_state;
            if (final_c)
                retired_count <= retired_count + CNT_W'(1);
        end
    end

    // Next-state and Moore output decode; everything forced low while in reset
    always_comb begin
        next_state  = state;
        final_c     = 1'b0;
        PCcontrol   = 1'b0;
        Mux1control = 1'b0;
        Mux6control = 2'd0;
        Mux2control = 1'b0;
        Mem_WE      = 1'b0;
        Dec1control = 1'b0;
        Reg_WE      = 1'b0;
        RegDst      = 2'd0;
        RegSrc      = 2'd0;
        ALUSrcB     = 1'b0;
        ALU3op      = ALU_ADD;
        retire      = 1'b0;
        illegal     = 1'b0;

        unique case (state)
            FETCH: begin
                Dec1control = 1'b1;
                next_state  = DECODE;
            end
            DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW:     next_state = MEMADDR;
                    OP_ADDI, OP_XORI: next_state = IMM_EX;
                    OP_BNE:           next_state = BRANCH;
`ifdef CTRL_BEQ_EN
                    OP_BEQ:           next_state = BRANCH;
`endif
                    OP_J:             next_state = JUMP;
                    OP_JAL:           next_state = JAL;
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT)
                            next_state = RTYPE_EX;
                        else if (funct == FN_JR)
                            next_state = JR;
                        else
                            next_state = ILLEGAL;
                    end
                    default:          next_state = ILLEGAL;
                endcase
            end
            MEMADDR: begin
                ALUSrcB    = 1'b1;
                next_state = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ALUSrcB     = 1'b1;
                Mux2control = 1'b1;
                next_state  = MEMWB;
            end
            MEMWB: begin
                ALUSrcB     = 1'b1;
                Mux2control = 1'b1;
                Reg_WE      = 1'b1;
                RegSrc      = 2'd1;
                PCcontrol   = 1'b1;
                final_c     = 1'b1;
            end
            MEMWRITE: begin
                ALUSrcB     = 1'b1;
                Mux2control = 1'b1;
                Mem_WE      = 1'b1;
                PCcontrol   = 1'b1;
                final_c     = 1'b1;
            end
            RTYPE_EX: begin
                ALU3op     = rtype_op_c;
                next_state = RTYPE_WB;
            end
            RTYPE_WB: begin
                ALU3op    = rtype_op_c;
                Reg_WE    = 1'b1;
                RegDst    = 2'd1;
                PCcontrol = 1'b1;
                final_c   = 1'b1;
            end
            IMM_EX: begin
                ALUSrcB    = 1'b1;
                ALU3op     = imm_op_c;
                next_state = IMM_WB;
            end
            IMM_WB: begin
                ALUSrcB   = 1'b1;
                ALU3op    = imm_op_c;
                Reg_WE    = 1'b1;
                PCcontrol = 1'b1;
                final_c   = 1'b1;
            end
            BRANCH: begin
                ALU3op      = ALU_SUB;
                Mux1control = taken_c;
                PCcontrol   = 1'b1;
                final_c     = 1'b1;
            end
            JUMP: begin
                Mux6control = 2'd1;
                PCcontrol   = 1'b1;
                final_c     = 1'b1;
            end
            JAL: begin
                Reg_WE      = 1'b1;
                RegDst      = 2'd2;
                RegSrc      = 2'd2;
                Mux6control = 2'd1;
                PCcontrol   = 1'b1;
                final_c     = 1'b1;
            end
            JR: begin
                Mux6control = 2'd2;
                PCcontrol   = 1'b1;
                final_c     = 1'b1;
            end
            ILLEGAL: begin
                illegal   = 1'b1;
                PCcontrol = 1'b1;
                final_c   = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        if (final_c)
            next_state = FETCH;
        retire = final_c;

        if (reset) begin
            final_c     = 1'b0;
            PCcontrol   = 1'b0;
            Mux1control = 1'b0;
            Mux6control = 2'd0;
            Mux2control = 1'b0;
            Mem_WE      = 1'b0;
            Dec1control = 1'b0;
            Reg_WE      = 1'b0;
            RegDst      = 2'd0;
            RegSrc      = 2'd0;
            ALUSrcB     = 1'b0;
            ALU3op      = ALU_ADD;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule
